// File: rtl/parity_pkg.sv
// Shared state encoding and parity-mode constants for the serial parity frame checker.
package parity_pkg;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_DATA   = 2'd1;
    localparam logic [1:0] ST_PARITY = 2'd2;

    localparam logic PAR_EVEN = 1'b0;
    localparam logic PAR_ODD  = 1'b1;

    typedef enum logic [1:0] {
        StIdle   = ST_IDLE,
        StData   = ST_DATA,
        StParity = ST_PARITY
    } state_e;

endpackage

// File: rtl/sat_counter.sv
// Up-counter that sticks at all-ones; cleared only by its asynchronous reset.
module sat_counter #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             inc_i,
    output logic [WIDTH-1:0] count_o
);

    logic [WIDTH-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (inc_i && (count_q != {WIDTH{1'b1}})) begin
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o = count_q;

endmodule

// File: rtl/parity_frame_checker.sv
// Serial parity checker: WORD_W data bits (MSB first) then one parity bit, even/odd per frame.
module parity_frame_checker
    import parity_pkg::*;
#(
    parameter int unsigned WORD_W = 4,
    parameter int unsigned ERR_W  = 8
) (
    input  logic                       clk_i,
    input  logic                       reset_i,
    input  logic                       clear_i,
    input  logic                       odd_mode_i,
    input  logic                       bit_valid_i,
    input  logic                       bit_in_i,
    output logic                       busy_o,
    output logic [$clog2(WORD_W+1)-1:0] bit_count_o,
    output logic [WORD_W-1:0]          data_out_o,
    output logic                       parity_out_o,
    output logic                       word_done_o,
    output logic                       parity_err_o,
    output logic [ERR_W-1:0]           err_count_o
);

    localparam int unsigned CntW = $clog2(WORD_W + 1);

    state_e              state_q, state_d;
    logic [WORD_W-1:0]   shreg_q, shreg_d;
    logic                acc_q, acc_d;
    logic                mode_q, mode_d;
    logic [CntW-1:0]     bit_count_q, bit_count_d;
    logic [WORD_W-1:0]   data_q, data_d;
    logic                parity_q, parity_d;
    logic                word_done_q, word_done_d;
    logic                parity_err_q, parity_err_d;
    logic                err_inc;
    logic                expected;

    // Odd mode is the complement of the running XOR of the data bits.
    assign expected = acc_q ^ (mode_q == PAR_ODD);

    always_comb begin
        state_d      = state_q;
        shreg_d      = shreg_q;
        acc_d        = acc_q;
        mode_d       = mode_q;
        bit_count_d  = bit_count_q;
        data_d       = data_q;
        parity_d     = parity_q;
        word_done_d  = 1'b0;
        parity_err_d = parity_err_q;
        err_inc      = 1'b0;

        if (clear_i) begin
            state_d      = StIdle;
            shreg_d      = '0;
            acc_d        = 1'b0;
            mode_d       = PAR_EVEN;
            bit_count_d  = '0;
            data_d       = '0;
            parity_d     = 1'b0;
            parity_err_d = 1'b0;
        end else if (bit_valid_i) begin
            unique case (state_q)
                StIdle: begin
                    shreg_d     = {{(WORD_W-1){1'b0}}, bit_in_i};
                    acc_d       = bit_in_i;
                    mode_d      = odd_mode_i;
                    bit_count_d = CntW'(1);
                    state_d     = StData;
                end
                StData: begin
                    shreg_d     = {shreg_q[WORD_W-2:0], bit_in_i};
                    acc_d       = acc_q ^ bit_in_i;
                    bit_count_d = bit_count_q + 1'b1;
                    if (bit_count_d == CntW'(WORD_W)) begin
                        state_d = StParity;
                    end
                end
                StParity: begin
                    data_d       = shreg_q;
                    parity_d     = expected;
                    parity_err_d = (bit_in_i != expected);
                    err_inc      = (bit_in_i != expected);
                    word_done_d  = 1'b1;
                    bit_count_d  = '0;
                    state_d      = StIdle;
                end
                default: begin
                    state_d = StIdle;
                end
            endcase
        end
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q      <= StIdle;
            shreg_q      <= '0;
            acc_q        <= 1'b0;
            mode_q       <= PAR_EVEN;
            bit_count_q  <= '0;
            data_q       <= '0;
            parity_q     <= 1'b0;
            word_done_q  <= 1'b0;
            parity_err_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            shreg_q      <= shreg_d;
            acc_q        <= acc_d;
            mode_q       <= mode_d;
            bit_count_q  <= bit_count_d;
            data_q       <= data_d;
            parity_q     <= parity_d;
            word_done_q  <= word_done_d;
            parity_err_q <= parity_err_d;
        end
    end

    sat_counter #(
        .WIDTH(ERR_W)
    ) u_err_cnt (
        .clk_i  (clk_i),
        .rst_i  (reset_i),
        .inc_i  (err_inc),
        .count_o(err_count_o)
    );

    assign busy_o       = (state_q != StIdle);
    assign bit_count_o  = bit_count_q;
    assign data_out_o   = data_q;
    assign parity_out_o = parity_q;
    assign word_done_o  = word_done_q;
    assign parity_err_o = parity_err_q;

endmodule

// File: tb/tb_parity_frame_checker.sv
// Directed + randomised bench for parity_frame_checker against an arithmetic parity model.
module tb_parity_frame_checker;

    localparam int W     = 4;
    localparam int EW    = 2;
    localparam int CW    = $clog2(W + 1);
    localparam int ERMAX = (1 << EW) - 1;

    logic          clk = 1'b0;
    logic          reset, clear, odd_mode, bit_valid, bit_in;
    logic          busy, parity_out, word_done, parity_err;
    logic [CW-1:0] bit_count;
    logic [W-1:0]  data_out;
    logic [EW-1:0] err_count;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int done_cyc = 0;
    int m_err    = 0;

    parity_frame_checker #(
        .WORD_W(W),
        .ERR_W (EW)
    ) dut (
        .clk_i       (clk),
        .reset_i     (reset),
        .clear_i     (clear),
        .odd_mode_i  (odd_mode),
        .bit_valid_i (bit_valid),
        .bit_in_i    (bit_in),
        .busy_o      (busy),
        .bit_count_o (bit_count),
        .data_out_o  (data_out),
        .parity_out_o(parity_out),
        .word_done_o (word_done),
        .parity_err_o(parity_err),
        .err_count_o (err_count)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Inputs change on the falling edge; the caller samples 1 time unit after the rising edge.
    task automatic drive(input logic v, input logic b);
        @(negedge clk);
        bit_valid = v;
        bit_in    = b;
        @(posedge clk);
        #1;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_busy"}, 32'(busy), 0);
        check({tag, "_cnt"}, 32'(bit_count), 0);
        check({tag, "_data"}, 32'(data_out), 0);
        check({tag, "_pout"}, 32'(parity_out), 0);
        check({tag, "_done"}, 32'(word_done), 0);
        check({tag, "_perr"}, 32'(parity_err), 0);
        check({tag, "_errc"}, 32'(err_count), 0);
    endtask

    task automatic send_frame(input logic [W-1:0] data, input logic mode, input logic corrupt,
                              input int gap_at, input int gap_len);
        logic par;
        logic sent;
        // Even: parity = popcount mod 2; odd mode flips it.
        par  = logic'(($countones(data) + int'(mode)) % 2);
        sent = par ^ corrupt;
        for (int i = 0; i < W; i++) begin
            odd_mode = (i == 0) ? mode : ~mode;
            drive(1'b1, data[W-1-i]);
            check("frm_busy", 32'(busy), 1);
            check("frm_cnt", 32'(bit_count), 32'(i + 1));
            check("frm_nodone", 32'(word_done), 0);
            if (i == gap_at) begin
                for (int g = 0; g < gap_len; g++) begin
                    drive(1'b0, 1'($urandom));
                    check("gap_busy", 32'(busy), 1);
                    check("gap_cnt", 32'(bit_count), 32'(i + 1));
                end
            end
        end
        drive(1'b1, sent);
        if (corrupt && m_err < ERMAX) m_err++;
        done_cyc = cyc;
        check("end_done", 32'(word_done), 1);
        check("end_data", 32'(data_out), 32'(data));
        check("end_pout", 32'(parity_out), 32'(par));
        check("end_perr", 32'(parity_err), 32'(corrupt));
        check("end_errc", 32'(err_count), 32'(m_err));
        check("end_busy", 32'(busy), 0);
        check("end_cnt", 32'(bit_count), 0);
    endtask

    initial begin
        logic [W-1:0] d;
        int prev;
        int sat_seq [5] = '{1, 2, 3, 3, 3};

        reset = 1'b1; clear = 1'b0; odd_mode = 1'b0; bit_valid = 1'b0; bit_in = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_all_zero("rst");
        @(negedge clk);
        reset = 1'b0;

        // Even parity, correct and corrupted, then an all-zero frame.
        send_frame(4'b1011, 1'b0, 1'b0, -1, 0);
        check("t1_pout", 32'(parity_out), 1);
        send_frame(4'b1011, 1'b0, 1'b1, -1, 0);
        check("t2_errc", 32'(err_count), 1);
        send_frame(4'b0000, 1'b0, 1'b0, -1, 0);
        check("t2b_perr", 32'(parity_err), 0);
        check("t2b_errc", 32'(err_count), 1);

        // Odd mode latched at the first bit; toggled afterwards inside send_frame.
        send_frame(4'b1100, 1'b1, 1'b0, -1, 0);
        check("t3_pout", 32'(parity_out), 1);
        drive(1'b0, 1'b0);
        check("idle_nodone", 32'(word_done), 0);
        check("idle_perr_held", 32'(parity_err), 0);

        // Three-cycle stall after the second data bit.
        d = W'($urandom);
        send_frame(d, 1'($urandom), 1'($urandom), 1, 3);

        // Back-to-back random frames, pulses exactly W+1 cycles apart.
        for (int f = 0; f < 6; f++) begin
            prev = done_cyc;
            d = W'($urandom);
            send_frame(d, 1'($urandom), 1'($urandom), -1, 0);
            if (f > 0) check("b2b_spacing", 32'(done_cyc - prev), 32'(W + 1));
        end
        drive(1'b0, 1'b0);
        check("b2b_tail_nodone", 32'(word_done), 0);

        // Abort after two data bits.
        odd_mode = 1'b1;
        drive(1'b1, 1'b1);
        drive(1'b1, 1'b0);
        check("pre_clr_cnt", 32'(bit_count), 2);
        clear = 1'b1;
        drive(1'b0, 1'b0);
        clear = 1'b0;
        check("clr_busy", 32'(busy), 0);
        check("clr_cnt", 32'(bit_count), 0);
        check("clr_done", 32'(word_done), 0);
        check("clr_data", 32'(data_out), 0);
        check("clr_perr", 32'(parity_err), 0);
        check("clr_pout", 32'(parity_out), 0);
        check("clr_errc", 32'(err_count), 32'(m_err));
        drive(1'b0, 1'b0);
        check("clr_post_done", 32'(word_done), 0);

        // clear wins over a simultaneous valid bit.
        clear = 1'b1;
        drive(1'b1, 1'b1);
        clear = 1'b0;
        check("clrv_busy", 32'(busy), 0);
        check("clrv_cnt", 32'(bit_count), 0);
        send_frame(4'b0110, 1'b0, 1'b0, -1, 0);

        // Asynchronous reset between clock edges mid-frame.
        drive(1'b1, 1'b1);
        drive(1'b1, 1'b1);
        #2;
        reset = 1'b1;
        #1;
        m_err = 0;
        check_all_zero("arst");
        @(negedge clk);
        reset = 1'b0;
        bit_valid = 1'b0;

        // Saturation of the 2-bit error counter.
        for (int f = 0; f < 5; f++) begin
            d = W'($urandom);
            send_frame(d, 1'($urandom), 1'b1, -1, 0);
            check("sat_seq", 32'(err_count), 32'(sat_seq[f]));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/parity_frame_checker.md
Name: parity_frame_checker

Overview:
- Serial parity generator/checker for framed bit streams: WORD_W data bits, then one parity bit, sampled one per clock when bit_valid is high.
- Accumulates parity and assembles the data word. Compares the received parity bit against the generated one. Even or odd parity is selectable per frame.
- Generalises the lab's fixed 4-input even-parity truth table to any width, adds a mode select, framing, a handshake and error counting.
- Sits between a serial bit source (switch/debounce or shift stage) and the display/LED logic.

Parameters:
- WORD_W, 4, data bits per frame (≥2).
- ERR_W, 8, width of the saturating error counter.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- clear  in  1  synchronous frame abort: state to IDLE, accumulators to 0; outputs other than err_count cleared.
- odd_mode  in  1  0 = even parity, 1 = odd parity; sampled on the first data bit of a frame.
- bit_valid  in  1  bit_in is valid this cycle.
- bit_in  in  1  serial bit; data MSB first, then the parity bit.
- busy  out  1  frame in progress (state DATA or PARITY).
- bit_count  out  $clog2(WORD_W+1)  data bits received in the current frame.
- data_out  out  WORD_W  assembled word; updated only at frame end.
- parity_out  out  1  generated parity for the last completed frame.
- word_done  out  1  one-cycle pulse at frame completion.
- parity_err  out  1  last completed frame's parity mismatch; held until the next word_done, clear or reset.
- err_count  out  ERR_W  count of frames with parity_err; saturates at all-ones; cleared only by reset.

Behaviour:
- Reset (async, active-high): state IDLE; shift register, acc, mode_q and bit_count all 0. All outputs 0.
- States: IDLE, DATA, PARITY. All registered; no combinational path from inputs to outputs.
- IDLE, bit_valid=1:
  - shreg <= {…, bit_in}; acc <= bit_in; mode_q <= odd_mode; bit_count <= 1.
  - Next state DATA, or PARITY if WORD_W==1 (not supported; WORD_W≥2).
- DATA, bit_valid=1:
  - shift bit_in into shreg LSB; acc ^= bit_in; bit_count++.
  - When bit_count becomes WORD_W, next state PARITY.
- DATA, bit_valid=0: hold all registers; no timeout.
- PARITY, bit_valid=1, with expected = acc ^ mode_q:
  - data_out <= shreg; parity_out <= expected.
  - parity_err <= (bit_in != expected); word_done <= 1 for one cycle.
  - err_count++ if mismatch and not saturated.
  - bit_count <= 0; next state IDLE.
- Latency: word_done, data_out, parity_out and parity_err become visible the cycle after the parity bit is sampled.
- Back-to-back frames: a valid bit in the cycle after the parity bit starts a new frame with no gap.
- Even mode: expected = XOR of the data bits, so the total ones including parity is even. Odd mode: the complement.
- odd_mode changes mid-frame are ignored; mode_q holds.
- Priority: reset > clear > bit_valid. clear with bit_valid in the same cycle discards the bit.
- clear mid-frame produces no word_done and leaves err_count unchanged.
- err_count at 2^ERR_W−1 stays there on further errors.
- word_done is 0 in every cycle except the completion cycle.

Decomposition:
- Shared package/header `parity_pkg`:
  - state encoding constants ST_IDLE=2'd0, ST_DATA=2'd1, ST_PARITY=2'd2;
  - PAR_EVEN=1'b0, PAR_ODD=1'b1.
- One sub-module, `sat_counter` (parametrised WIDTH, inc and reset inputs), used for err_count.
- Datapath and FSM stay in the top module.

Test Plan:
- Even, no error: WORD_W=4, odd_mode=0, bits 1,0,1,1 then parity 1 → word_done pulses once; data_out=4'b1011, parity_out=1, parity_err=0, err_count=0.
- Even, error: same data, parity bit 0 → parity_err=1, err_count=1. Then a frame 0,0,0,0 with parity 0 → parity_err=0, err_count=1.
- Odd mode, sampled at first bit: odd_mode=1 at the first bit and toggled to 0 mid-frame; bits 1,1,0,0, parity 1 → parity_out=1, parity_err=0.
- Gaps and back-to-back frames: bit_valid low for 3 cycles mid-frame → bit_count holds, busy=1. Two frames back-to-back with no idle cycle → two word_done pulses 5 cycles apart.
- Abort and simultaneous events:
  - clear after 2 data bits → busy=0, bit_count=0, no word_done.
  - clear with bit_valid in the same cycle → bit ignored.
  - Async reset asserted mid-frame between clock edges → all outputs 0 immediately.
- Saturation: ERR_W=2, 5 erroneous frames → err_count sequence 1,2,3,3,3.
